// File: rtl/edit_pkg.sv
// rtl/edit_pkg.sv - shared state encoding and grid geometry for the edit cursor
package edit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int DEF_GRID_COLS = 20;
  localparam int DEF_GRID_ROWS = 15;
  localparam int CELL_IDX_W    = 9;
  localparam int X_W           = 5;
  localparam int Y_W           = 4;

endpackage

// File: rtl/cell_cursor.sv
// rtl/cell_cursor.sv - x/y cell registers with load, wrapping arrow moves and advance-with-carry
module cell_cursor
  import edit_pkg::*;
#(
  parameter int GRID_COLS = DEF_GRID_COLS,
  parameter int GRID_ROWS = DEF_GRID_ROWS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic [Y_W-1:0] load_y,
  input  logic           mv_up,
  input  logic           mv_down,
  input  logic           mv_left,
  input  logic           mv_right,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  localparam logic [X_W-1:0] X_MAX = X_W'(GRID_COLS - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_ROWS - 1);

  // Operations are mutually exclusive in practice; the order below only
  // resolves simultaneous arrow keys (up > down > left > right).
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= load_x;
      y <= load_y;
    end else if (advance) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end else if (mv_up) begin
      y <= (y == '0) ? Y_MAX : y - 1'b1;
    end else if (mv_down) begin
      y <= (y == Y_MAX) ? '0 : y + 1'b1;
    end else if (mv_left) begin
      x <= (x == '0) ? X_MAX : x - 1'b1;
    end else if (mv_right) begin
      x <= (x == X_MAX) ? '0 : x + 1'b1;
    end
  end

endmodule

// File: rtl/edit_cursor_ctrl.sv
// rtl/edit_cursor_ctrl.sv - handwriting cell cursor FSM with commit handshake and ack timeout
module edit_cursor_ctrl
  import edit_pkg::*;
#(
  parameter int GRID_COLS   = DEF_GRID_COLS,
  parameter int GRID_ROWS   = DEF_GRID_ROWS,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            MOUSE_X_POS,
  input  logic [8:0]            MOUSE_Y_POS,
  input  logic                  mouse_click_l,
  input  logic                  key_up,
  input  logic                  key_down,
  input  logic                  key_left,
  input  logic                  key_right,
  input  logic                  key_commit,
  input  logic                  key_cancel,
  input  logic                  commit_ack,
  output logic                  editing,
  output logic [X_W-1:0]        writing_block_x_pos,
  output logic [Y_W-1:0]        writing_block_y_pos,
  output logic                  canvas_clear,
  output logic                  commit_req,
  output logic [CELL_IDX_W-1:0] commit_addr,
  output logic                  commit_err
);

  localparam int                CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic                    clear_nx, req_nx, err_nx;
  logic [CELL_IDX_W-1:0]   addr_nx;
  logic                    cur_load, cur_adv, cur_up, cur_down, cur_left, cur_right;
  logic [X_W-1:0]          x, click_x;
  logic [Y_W-1:0]          y, click_y;
  logic                    click_in_grid, any_arrow;
  logic                    unused_pixel_bits;

  assign click_x           = MOUSE_X_POS[9:5];
  assign click_y           = MOUSE_Y_POS[8:5];
  assign unused_pixel_bits = ^{MOUSE_X_POS[4:0], MOUSE_Y_POS[4:0]};
  assign click_in_grid     = mouse_click_l && (int'(click_x) < GRID_COLS)
                                           && (int'(click_y) < GRID_ROWS);
  assign any_arrow         = key_up | key_down | key_left | key_right;

  // Row-major cell index; the default 20-column grid uses y*16 + y*4.
  function automatic logic [CELL_IDX_W-1:0] cell_index(input logic [X_W-1:0] cx,
                                                      input logic [Y_W-1:0] cy);
    logic [CELL_IDX_W-1:0] xw, yw;
    xw = CELL_IDX_W'(cx);
    yw = CELL_IDX_W'(cy);
    if (GRID_COLS == 20) return (yw << 4) + (yw << 2) + xw;
    else                 return (yw * CELL_IDX_W'(GRID_COLS)) + xw;
  endfunction

  cell_cursor #(
    .GRID_COLS (GRID_COLS),
    .GRID_ROWS (GRID_ROWS)
  ) u_cursor (
    .clk      (clk),
    .rst      (rst),
    .load     (cur_load),
    .load_x   (click_x),
    .load_y   (click_y),
    .mv_up    (cur_up),
    .mv_down  (cur_down),
    .mv_left  (cur_left),
    .mv_right (cur_right),
    .advance  (cur_adv),
    .x        (x),
    .y        (y)
  );

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    clear_nx  = 1'b0;
    req_nx    = commit_req;
    err_nx    = 1'b0;
    addr_nx   = commit_addr;
    cur_load  = 1'b0;
    cur_adv   = 1'b0;
    cur_up    = 1'b0;
    cur_down  = 1'b0;
    cur_left  = 1'b0;
    cur_right = 1'b0;
    case (state)
      ST_IDLE: begin
        if (click_in_grid) begin
          state_nx = ST_EDIT;
          cur_load = 1'b1;
          clear_nx = 1'b1;
        end
      end
      ST_EDIT: begin
        if (key_cancel) begin
          state_nx = ST_IDLE;
        end else if (key_commit) begin
          state_nx = ST_COMMIT;
          req_nx   = 1'b1;
          addr_nx  = cell_index(x, y);
          cnt_nx   = '0;
        end else if (click_in_grid) begin
          if (click_x != x || click_y != y) begin
            cur_load = 1'b1;
            clear_nx = 1'b1;
          end
        end else if (any_arrow) begin
          cur_up    = key_up;
          cur_down  = key_down;
          cur_left  = key_left;
          cur_right = key_right;
          clear_nx  = 1'b1;
        end
      end
      ST_COMMIT: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (commit_ack) begin
          state_nx = ST_EDIT;
          cur_adv  = 1'b1;
          clear_nx = 1'b1;
          req_nx   = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nx = ST_EDIT;
          err_nx   = 1'b1;
          req_nx   = 1'b0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      editing      <= 1'b0;
      canvas_clear <= 1'b0;
      commit_req   <= 1'b0;
      commit_addr  <= '0;
      commit_err   <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      editing      <= (state_nx != ST_IDLE);
      canvas_clear <= clear_nx;
      commit_req   <= req_nx;
      commit_addr  <= addr_nx;
      commit_err   <= err_nx;
    end
  end

  assign writing_block_x_pos = x;
  assign writing_block_y_pos = y;

endmodule
